// File: rtl/anc_out_buffer_if.sv
// Bus bundle for anc_out_buffer: CORDIC-side sample strobe, consumer valid/ready, status.
// Optional drop_cnt signal exists only when ANC_OUT_DROP_CNT_EN is defined.
interface anc_out_buffer_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
);
  logic              enable_in;
  logic [DATA_W-1:0] x_re_in;
  logic [DATA_W-1:0] x_im_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_re;
  logic [DATA_W-1:0] out_im;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
`ifdef ANC_OUT_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  // slave: the buffer itself; master: the environment driving it.
  modport slave (
    input  enable_in, x_re_in, x_im_in, out_ready,
    output out_valid, out_re, out_im, count, full, empty, overflow
`ifdef ANC_OUT_DROP_CNT_EN
    , output drop_cnt
`endif
  );

  modport master (
    output enable_in, x_re_in, x_im_in, out_ready,
    input  out_valid, out_re, out_im, count, full, empty, overflow
`ifdef ANC_OUT_DROP_CNT_EN
    , input drop_cnt
`endif
  );
endinterface

// File: rtl/anc_out_buffer.sv
// First-word-fall-through circular FIFO behind the rotation CORDIC; drops (never stalls) on full.
// Optional per-drop saturating counter enabled by macro ANC_OUT_DROP_CNT_EN.
module anc_out_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  anc_out_buffer_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a head entry transfers on any rising edge where out_valid && out_ready.
  // out_valid depends on registered count only, never on enable_in or out_ready.
  logic [DATA_W-1:0] mem_re [DEPTH];
  logic [DATA_W-1:0] mem_im [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             overflow_q;

  logic full_w;
  logic empty_w;
  logic rd_fire;
  logic wr_en;
  logic drop;

  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign empty_w = (count_q == '0);
  assign rd_fire = !empty_w && bus.out_ready;
  // A read in the same cycle frees the slot, so a full FIFO still accepts the sample.
  assign wr_en   = bus.enable_in && (!full_w || rd_fire);
  assign drop    = bus.enable_in && full_w && !rd_fire;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // DEPTH is a power of two, so natural pointer rollover is the modulo wrap.
      if (wr_en)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_d;
      if (drop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem_re[wr_ptr] <= bus.x_re_in;
      mem_im[wr_ptr] <= bus.x_im_in;
    end
  end

  assign bus.out_valid = !empty_w;
  assign bus.out_re    = empty_w ? '0 : mem_re[rd_ptr];
  assign bus.out_im    = empty_w ? '0 : mem_im[rd_ptr];
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = overflow_q;

`ifdef ANC_OUT_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_anc_out_buffer.sv
// Directed bench for anc_out_buffer: vector table for basic flow, hand sequences for full/wrap/reset.
module tb_anc_out_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 5;

  logic clk;
  logic reset;

  anc_out_buffer_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  anc_out_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic              en;
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic              rdy;
    logic              ev;
    logic [DATA_W-1:0] ere;
    logic [DATA_W-1:0] eim;
    logic [CNT_W-1:0]  ecnt;
  } vec_t;

  vec_t tbl [13];

  // driver tasks
  task automatic step(input logic en, input logic [DATA_W-1:0] re,
                      input logic [DATA_W-1:0] im, input logic rdy);
    @(negedge clk);
    bus.enable_in = en;
    bus.x_re_in   = re;
    bus.x_im_in   = im;
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    @(negedge clk);
    reset         = 1'b1;
    bus.enable_in = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // scoreboard check: full/empty expectations follow from expected count
  task automatic check(input string name, input logic ev, input logic [DATA_W-1:0] ere,
                       input logic [DATA_W-1:0] eim, input logic [CNT_W-1:0] ecnt,
                       input logic eovf);
    logic efull, eempty;
    efull  = (ecnt == CNT_W'(DEPTH));
    eempty = (ecnt == '0);
    n_vec++;
    if (bus.out_valid !== ev || bus.out_re !== ere || bus.out_im !== eim ||
        bus.count !== ecnt || bus.full !== efull || bus.empty !== eempty ||
        bus.overflow !== eovf) begin
      n_err++;
      $display("FAIL %s: got v=%b re=%h im=%h cnt=%0d f=%b e=%b ovf=%b, want v=%b re=%h im=%h cnt=%0d f=%b e=%b ovf=%b",
               name, bus.out_valid, bus.out_re, bus.out_im, bus.count, bus.full, bus.empty,
               bus.overflow, ev, ere, eim, ecnt, efull, eempty, eovf);
    end
  endtask

  function automatic logic [DATA_W-1:0] neg(input int v);
    return DATA_W'(-v);
  endfunction

  // expected queue for drain ordering
  logic [DATA_W-1:0] exp_q [$];

  initial begin
    reset         = 1'b1;
    bus.enable_in = 1'b0;
    bus.x_re_in   = '0;
    bus.x_im_in   = '0;
    bus.out_ready = 1'b0;

    tbl[0]  = '{1'b1, 32'h0001_0000, 32'hFFFF_8000, 1'b0, 1'b1, 32'h0001_0000, 32'hFFFF_8000, 5'd1};
    tbl[1]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0001_0000, 32'hFFFF_8000, 5'd1};
    tbl[2]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0001_0000, 32'hFFFF_8000, 5'd1};
    tbl[3]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0001_0000, 32'hFFFF_8000, 5'd1};
    tbl[4]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0001_0000, 32'hFFFF_8000, 5'd1};
    tbl[5]  = '{1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0001_0000, 32'hFFFF_8000, 5'd1};
    tbl[6]  = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         5'd0};
    tbl[7]  = '{1'b1, 32'h5,         32'h6,         1'b1, 1'b1, 32'h5,         32'h6,         5'd1};
    tbl[8]  = '{1'b1, 32'h7,         32'h8,         1'b0, 1'b1, 32'h5,         32'h6,         5'd2};
    tbl[9]  = '{1'b1, 32'h9,         32'hA,         1'b1, 1'b1, 32'h7,         32'h8,         5'd2};
    tbl[10] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b1, 32'h9,         32'hA,         5'd1};
    tbl[11] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         5'd0};
    tbl[12] = '{1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0,         32'h0,         5'd0};

    // reset held 2 cycles with a sample strobe present
    @(negedge clk);
    bus.enable_in = 1'b1;
    bus.x_re_in   = 32'h0000_1234;
    do_reset(2);
    check("reset", 1'b0, '0, '0, 5'd0, 1'b0);

    // table vectors: single write/hold/pop, ready-while-empty, simultaneous write+read
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].re, tbl[i].im, tbl[i].rdy);
      check($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ere, tbl[i].eim, tbl[i].ecnt, 1'b0);
    end

    // 20 writes into a 16-deep FIFO: last four dropped
    for (int v = 1; v <= 20; v++) begin
      step(1'b1, DATA_W'(v), neg(v), 1'b0);
      if (v == 16) check("full_at_16", 1'b1, 32'd1, neg(1), 5'd16, 1'b0);
    end
    check("after_drops", 1'b1, 32'd1, neg(1), 5'd16, 1'b1);
`ifdef ANC_OUT_DROP_CNT_EN
    n_vec++;
    if (bus.drop_cnt !== 16'd4) begin
      n_err++;
      $display("FAIL drop_cnt: got %0d want 4", bus.drop_cnt);
    end
`endif
    for (int v = 1; v <= 16; v++) begin
      check($sformatf("drain%0d", v), 1'b1, DATA_W'(v), neg(v), CNT_W'(17 - v), 1'b1);
      step(1'b0, '0, '0, 1'b1);
    end
    check("drained", 1'b0, '0, '0, 5'd0, 1'b1);

    // full FIFO with simultaneous write and read
    do_reset(1);
    for (int v = 100; v < 116; v++) begin
      step(1'b1, DATA_W'(v), DATA_W'(v + 1000), 1'b0);
      exp_q.push_back(DATA_W'(v));
    end
    check("full_again", 1'b1, 32'd100, 32'd1100, 5'd16, 1'b0);
    step(1'b1, 32'd99, 32'd1099, 1'b1);
    void'(exp_q.pop_front());
    exp_q.push_back(32'd99);
    check("full_wr_rd", 1'b1, 32'd101, 32'd1101, 5'd16, 1'b0);
    for (int k = 0; k < 16; k++) begin
      logic [DATA_W-1:0] e;
      e = exp_q.pop_front();
      check($sformatf("full_drain%0d", k), 1'b1, e, e + 32'd1000, CNT_W'(16 - k), 1'b0);
      step(1'b0, '0, '0, 1'b1);
    end
    check("full_drained", 1'b0, '0, '0, 5'd0, 1'b0);

    // 40 cycles of continuous write+read: pointers wrap twice, count stays 1
    for (int k = 1; k <= 40; k++) begin
      step(1'b1, DATA_W'(k), neg(k), 1'b1);
      check($sformatf("stream%0d", k), 1'b1, DATA_W'(k), neg(k), 5'd1, 1'b0);
    end
    step(1'b0, '0, '0, 1'b1);
    check("stream_end", 1'b0, '0, '0, 5'd0, 1'b0);

    // build count=7 with overflow set, then reset mid-stream
    for (int v = 1; v <= 17; v++) step(1'b1, DATA_W'(v), neg(v), 1'b0);
    repeat (9) step(1'b0, '0, '0, 1'b1);
    check("pre_reset", 1'b1, 32'd10, neg(10), 5'd7, 1'b1);
    do_reset(1);
    check("mid_reset", 1'b0, '0, '0, 5'd0, 1'b0);
    step(1'b1, 32'h0000_ABCD, 32'h1234_5678, 1'b0);
    check("post_reset_wr", 1'b1, 32'h0000_ABCD, 32'h1234_5678, 5'd1, 1'b0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
